// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-requester multiplier arbiter:
// operand/product widths and the arbiter FSM state encoding.
package mult_arb_pkg;

    localparam int OPND_W = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SRV0 = 2'b01,
        S_SRV1 = 2'b10
    } state_t;

endpackage

// File: rtl/mult_arb_if.sv
// Requester-side bus of mult_arb: operand handshakes, results and statistics
// for both requesters. The master modport is the requester side, the slave
// modport is the arbiter side.
interface mult_arb_if;
    import mult_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic [OPND_W-1:0] a0;
    logic [OPND_W-1:0] b0;
    logic [OPND_W-1:0] a1;
    logic [OPND_W-1:0] b1;
    logic              gnt0;
    logic              gnt1;
    logic [PROD_W-1:0] x0;
    logic [PROD_W-1:0] x1;
    logic              x_valid0;
    logic              x_valid1;
    logic [15:0]       cnt0;
    logic [15:0]       cnt1;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  gnt0, gnt1, x0, x1, x_valid0, x_valid1, cnt0, cnt1
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output gnt0, gnt1, x0, x1, x_valid0, x_valid1, cnt0, cnt1
    );

endinterface

// File: rtl/mult_arb_mult.sv
// Combinational 8x8 unsigned multiplier returning the full 16-bit product.
module mult
    import mult_arb_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] x
);

    assign x = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult_arb.sv
// Two-requester arbiter in front of one shared multiplier. Requesters are
// served in bursts of up to BURST transactions; products come back one cycle
// after acceptance, steered to the requester that issued them.
// Optional feature: define MULT_ARB_STAT_EN to build saturating per-port
// transaction counters on cnt0/cnt1 (otherwise they read 0).
module mult_arb
    import mult_arb_pkg::*;
#(
    parameter int BURST = 4
)
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   halt,
    mult_arb_if.slave bus
);

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_t            state;
    state_t            next_state;
    logic              last;
    logic [3:0]        burst_cnt;
    logic [3:0]        burst_nxt;
    logic              gnt0;
    logic              gnt1;
    logic              txn0;
    logic              txn1;
    logic              txn;
    logic              burst_hit;
    logic [OPND_W-1:0] opa;
    logic [OPND_W-1:0] opb;
    logic [PROD_W-1:0] prod_p0;
    logic [PROD_W-1:0] prod_p1;
    logic              tag_p1;
    logic              vld_p1;
    logic [PROD_W-1:0] hold0;
    logic [PROD_W-1:0] hold1;

    // Grants are masked by halt in the same cycle so nothing new is accepted.
    assign gnt0      = (state == S_SRV0) && !halt;
    assign gnt1      = (state == S_SRV1) && !halt;
    assign txn0      = bus.req0 && gnt0;
    assign txn1      = bus.req1 && gnt1;
    assign txn       = txn0 || txn1;
    assign burst_hit = txn && ((burst_cnt + 4'd1) == BURST_L);
    assign bus.gnt0  = gnt0;
    assign bus.gnt1  = gnt1;

    // Next-state selection: tie from idle goes to the requester not served last.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.req0 && bus.req1) next_state = last ? S_SRV0 : S_SRV1;
                else if (bus.req0)        next_state = S_SRV0;
                else if (bus.req1)        next_state = S_SRV1;
            end
            S_SRV0: begin
                if (halt)                        next_state = S_IDLE;
                else if (!bus.req0)              next_state = bus.req1 ? S_SRV1 : S_IDLE;
                else if (burst_hit && bus.req1)  next_state = S_SRV1;
            end
            S_SRV1: begin
                if (halt)                        next_state = S_IDLE;
                else if (!bus.req1)              next_state = bus.req0 ? S_SRV0 : S_IDLE;
                else if (burst_hit && bus.req0)  next_state = S_SRV0;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Burst length counter: restarts on any state change, saturates at BURST.
    always_comb begin
        burst_nxt = burst_cnt;
        if (next_state != state)              burst_nxt = 4'd0;
        else if (txn && burst_cnt != BURST_L) burst_nxt = burst_cnt + 4'd1;
    end

    // Arbiter state, burst count and last-served requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            burst_cnt <= 4'd0;
            last      <= 1'b1;
        end else begin
            state     <= next_state;
            burst_cnt <= burst_nxt;
            if (txn0)      last <= 1'b0;
            else if (txn1) last <= 1'b1;
        end
    end

    assign opa = txn1 ? bus.a1 : bus.a0;
    assign opb = txn1 ? bus.b1 : bus.b0;

    mult u_mult (
        .a (opa),
        .b (opb),
        .x (prod_p0)
    );

    // Stage p0 -> p1: capture product with its destination tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            tag_p1  <= 1'b0;
            prod_p1 <= '0;
        end else begin
            vld_p1 <= txn;
            if (txn) begin
                prod_p1 <= prod_p0;
                tag_p1  <= txn1;
            end
        end
    end

    // Per-port hold of the last delivered product so each output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
            hold1 <= '0;
        end else if (vld_p1) begin
            if (tag_p1) hold1 <= prod_p1;
            else        hold0 <= prod_p1;
        end
    end

    assign bus.x_valid0 = vld_p1 && !tag_p1;
    assign bus.x_valid1 = vld_p1 &&  tag_p1;
    assign bus.x0       = bus.x_valid0 ? prod_p1 : hold0;
    assign bus.x1       = bus.x_valid1 ? prod_p1 : hold1;

`ifdef MULT_ARB_STAT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating accepted-transaction counters per port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (txn0) cnt0 <= sat_inc(cnt0);
            if (txn1) cnt1 <= sat_inc(cnt1);
        end
    end

    assign bus.cnt0 = cnt0;
    assign bus.cnt1 = cnt1;
`else
    assign bus.cnt0 = '0;
    assign bus.cnt1 = '0;
`endif

endmodule

// File: tb/tb_mult_arb.sv
// Testbench for mult_arb: directed scenarios followed by random traffic,
// all checked against a behavioural arbitration/product model.
module tb_mult_arb;

    localparam int BURST = 4;
`ifdef MULT_ARB_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic halt;

    mult_arb_if bus ();

    mult_arb #(.BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .halt  (halt),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: owner -1 = nobody served
    int          m_owner;
    int          m_run;
    int          m_last;
    bit          m_v0, m_v1;
    logic [15:0] m_x0, m_x1;
    int          tot0, tot1;

    // values sampled at the last check point
    logic        samp_g0, samp_g1, samp_xv0, samp_xv1;
    logic [15:0] samp_x0, samp_x1, samp_c0, samp_c1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int tot);
        if (!STAT) return 16'd0;
        return (tot > 65535) ? 16'hFFFF : 16'(tot);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_last = 1;
        m_v0 = 0; m_v1 = 0; m_x0 = '0; m_x1 = '0;
        tot0 = 0; tot1 = 0;
    endtask

    task automatic model_edge();
        bit r0, r1, h, t0, t1, rk, ro;
        int nxt, k, p;
        r0 = bus.req0; r1 = bus.req1; h = halt;
        t0 = r0 && (m_owner == 0) && !h;
        t1 = r1 && (m_owner == 1) && !h;
        m_v0 = t0; m_v1 = t1;
        if (t0) begin p = int'(bus.a0) * int'(bus.b0); m_x0 = p[15:0]; tot0++; end
        if (t1) begin p = int'(bus.a1) * int'(bus.b1); m_x1 = p[15:0]; tot1++; end
        if (m_owner < 0) begin
            if (r0 && r1)  nxt = (m_last == 1) ? 0 : 1;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else begin
            k  = m_owner;
            rk = (k == 0) ? r0 : r1;
            ro = (k == 0) ? r1 : r0;
            if (h)                                 nxt = -1;
            else if (!rk)                          nxt = ro ? 1 - k : -1;
            else if ((m_run + 1 == BURST) && ro)   nxt = 1 - k;
            else                                   nxt = k;
        end
        if (nxt != m_owner)                     m_run = 0;
        else if ((t0 || t1) && m_run < BURST)   m_run++;
        m_owner = nxt;
        if (t0) m_last = 0;
        if (t1) m_last = 1;
    endtask

    task automatic check_outputs();
        samp_g0 = bus.gnt0; samp_g1 = bus.gnt1;
        samp_xv0 = bus.x_valid0; samp_xv1 = bus.x_valid1;
        samp_x0 = bus.x0; samp_x1 = bus.x1;
        samp_c0 = bus.cnt0; samp_c1 = bus.cnt1;
        chk("gnt0", 32'(samp_g0), 32'((m_owner == 0) && !halt));
        chk("gnt1", 32'(samp_g1), 32'((m_owner == 1) && !halt));
        chk("x_valid0", 32'(samp_xv0), 32'(m_v0));
        chk("x_valid1", 32'(samp_xv1), 32'(m_v1));
        chk("x0", 32'(samp_x0), 32'(m_x0));
        chk("x1", 32'(samp_x1), 32'(m_x1));
        chk("cnt0", 32'(samp_c0), 32'(exp_cnt(tot0)));
        chk("cnt1", 32'(samp_c1), 32'(exp_cnt(tot1)));
    endtask

    // one clock: check mid-cycle, advance model on the edge, return 1 after it
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
        chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
        chk({tag, "_xv0"}, 32'(bus.x_valid0), 32'd0);
        chk({tag, "_xv1"}, 32'(bus.x_valid1), 32'd0);
        chk({tag, "_x0"}, 32'(bus.x0), 32'd0);
        chk({tag, "_x1"}, 32'(bus.x1), 32'd0);
        chk({tag, "_cnt0"}, 32'(bus.cnt0), 32'd0);
        chk({tag, "_cnt1"}, 32'(bus.cnt1), 32'd0);
    endtask

    // called 1 time unit after a rising edge; reset lies entirely between edges
    task automatic reset_pulse(input string tag);
        #1 rst_n = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [10];
        seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

        rst_n = 1'b0; halt = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all_zero("rst");
        rst_n = 1'b1;

        // single requester: 12 * 10
        bus.req0 = 1'b1; bus.a0 = 8'd12; bus.b0 = 8'd10;
        cycle();
        chk("idle_no_gnt0", 32'(samp_g0), 32'd0);
        cycle();
        chk("first_gnt0", 32'(samp_g0), 32'd1);
        bus.req0 = 1'b0;
        cycle();
        chk("x0_120", 32'(samp_x0), 32'd120);
        chk("x0_120_vld", 32'(samp_xv0), 32'd1);
        chk("x0_120_xv1", 32'(samp_xv1), 32'd0);
        cycle();

        // both requesting from idle: bursts of BURST alternate
        reset_pulse("rst_b");
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
            bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
            cycle();
            chk($sformatf("burst_g0_%0d", i), 32'(samp_g0), 32'(seq[i] == 0));
            chk($sformatf("burst_g1_%0d", i), 32'(samp_g1), 32'(seq[i] == 1));
        end

        // full-range product on port 1
        bus.req0 = 1'b0; bus.req1 = 1'b1; bus.a1 = 8'd255; bus.b1 = 8'd255;
        cycle();
        cycle();
        chk("gnt1_ff", 32'(samp_g1), 32'd1);
        cycle();
        chk("x1_fe01", 32'(samp_x1), 32'h0000FE01);
        chk("x1_fe01_vld", 32'(samp_xv1), 32'd1);

        // halt mid-burst on port 1: grant masked, in-flight result delivered
        halt = 1'b1;
        cycle();
        chk("halt_gnt1", 32'(samp_g1), 32'd0);
        chk("halt_inflight", 32'(samp_xv1), 32'd1);
        halt = 1'b0;
        cycle();
        chk("halt_idle_gnt1", 32'(samp_g1), 32'd0);
        chk("halt_once", 32'(samp_xv1), 32'd0);
        cycle();

        // reset pulse mid-burst
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        repeat (3) cycle();
        reset_pulse("rst_mid");
        cycle();
        chk("post_rst_xv0", 32'(samp_xv0), 32'd0);
        chk("post_rst_xv1", 32'(samp_xv1), 32'd0);
        cycle();

        // statistics: 5 on port 0, then 3 on port 1
        reset_pulse("rst_s");
        bus.req1 = 1'b0; bus.req0 = 1'b1;
        for (int i = 0; i < 30 && tot0 < 5; i++) cycle();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        for (int i = 0; i < 30 && tot1 < 3; i++) cycle();
        bus.req1 = 1'b0;
        chk("stat_tx0", 32'(tot0), 32'd5);
        chk("stat_tx1", 32'(tot1), 32'd3);
        cycle();
        cycle();
        chk("stat_cnt0", 32'(samp_c0), STAT ? 32'd5 : 32'd0);
        chk("stat_cnt1", 32'(samp_c1), STAT ? 32'd3 : 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.req0 = ($urandom_range(0, 3) != 0);
            bus.req1 = ($urandom_range(0, 3) != 0);
            halt     = ($urandom_range(0, 9) == 0);
            bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
            bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
            cycle();
        end
        halt = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
- REQ-001: Parameter BURST, default 4, SHALL set the maximum consecutive accepted transactions per requester while the other requester waits (legal range 1..15).
- REQ-002: CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-003: RST_N  input  1  SHALL be the reset: asynchronous assertion, active-low.
- REQ-004: HALT  input  1  SHALL abort current service, synchronous.
- REQ-005: REQ0 / REQ1  input  1  SHALL indicate that requester 0 / 1 presents valid operands.
- REQ-006: A0, B0 / A1, B1  input  8 each  SHALL carry the unsigned operands of requester 0 / 1.
- REQ-007: GNT0 / GNT1  output  1  SHALL indicate that the operands of requester 0 / 1 are accepted this cycle when the matching REQ is high.
- REQ-008: X0 / X1  output  16  SHALL carry the product returned to requester 0 / 1.
- REQ-009: X_VALID0 / X_VALID1  output  1  SHALL be a one-cycle pulse qualifying X0 / X1.
- REQ-010: CNT0 / CNT1  output  16  SHALL carry the accepted-transaction statistics (see Configuration).

Function
- REQ-011: The FSM SHALL have the states S_IDLE, S_SRV0 and S_SRV1.
- REQ-012: GNTk SHALL equal (state==S_SRVk) && !HALT, combinationally; a transaction on port k is REQk && GNTk.
- REQ-013: No grant SHALL be issued in S_IDLE; leaving S_IDLE costs exactly one cycle.
- REQ-014: S_IDLE SHALL move to S_SRVk for a single requester; with both requesting it SHALL move to the requester not recorded in the LAST register.
- REQ-015: In S_SRVk, HALT SHALL force S_IDLE with priority over every other transition.
- REQ-016: S_SRVk with REQk low SHALL go to S_SRV(other) if the other requester is requesting, else to S_IDLE.
- REQ-017: S_SRVk SHALL move to S_SRV(other) after the transaction that brings the burst counter to BURST while the other requester is requesting; otherwise it SHALL stay in S_SRVk.
- REQ-018: The burst counter SHALL clear on every state change and increment per transaction; it SHALL saturate at BURST when no switch occurs.
- REQ-019: LAST SHALL update to k on each transaction on port k.
- REQ-020: Operands of a transaction SHALL feed the shared 8x8 unsigned multiplier; the full 16-bit product SHALL be registered together with a one-bit destination tag.
- REQ-021: Latency SHALL be one cycle: a transaction at edge t SHALL give Xk = product and X_VALIDk = 1 during cycle t+1, with the other X_VALID low.
- REQ-022: Xk SHALL hold its last value when X_VALIDk is low.
- REQ-023: A transaction accepted in the same cycle HALT rises cannot occur, because GNT is masked; a result already in the register SHALL still be delivered.
- REQ-024: Back-to-back transactions SHALL sustain one product per cycle with no bubble inside a burst.

Reset
- REQ-025: RST_N low SHALL asynchronously set state = S_IDLE, LAST = 1 (so requester 0 wins the first tie), burst counter = 0, X0 = X1 = 0, X_VALID0 = X_VALID1 = 0 and CNT0 = CNT1 = 0.
- REQ-026: A reset mid-burst SHALL discard the pending result with no X_VALID pulse.

Configuration
- REQ-027: With MULT_ARB_STAT_EN defined, CNTk SHALL increment per transaction on port k and saturate at 16'hFFFF.
- REQ-028: Without MULT_ARB_STAT_EN, CNT0 and CNT1 SHALL be tied to 0 and no counter flops SHALL be built.

Structure
- REQ-029: Package mult_arb_pkg SHALL hold the state encoding localparams (S_IDLE = 2'b00, S_SRV0 = 2'b01, S_SRV1 = 2'b10), the operand width 8 and the product width 16.
- REQ-030: The only sub-module SHALL be one instance of the team's existing combinational multiplier mult (a, b -> x).

Verification
- REQ-031: Reset release, then REQ0 = 1 with A0 = 12, B0 = 10 -> GNT0 one cycle after leaving S_IDLE; X0 = 120 with X_VALID0 pulse on the next cycle; X_VALID1 stays 0.
- REQ-032: REQ0 and REQ1 held high from S_IDLE, BURST = 4 -> grants 0,0,0,0,1,1,1,1,0,... with one product per cycle; tags match ports.
- REQ-033: Operands A1 = 255, B1 = 255 -> X1 = 65025 (16'hFE01), no truncation.
- REQ-034: HALT asserted mid-burst on port 1 -> GNT1 drops in the same cycle, state S_IDLE next edge, in-flight product still delivered once.
- REQ-035: RST_N pulsed low between edges during a burst -> all outputs 0 immediately, no X_VALID after release until a new transaction.
- REQ-036: With MULT_ARB_STAT_EN, 5 transactions on port 0 and 3 on port 1 -> CNT0 = 5 and CNT1 = 3; without the macro both read 0.
